// File: rtl/mem_req_arbiter.sv
// Arbitrates an instruction and a data requester onto one RAM port, data first,
// with an instruction starvation override. Optional RAM-timeout fault: MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        fault
);

`ifdef MEM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, IACC, DACC, FAULT} state_e;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_e;
`endif

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wen_q, wen_d;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;
`endif

  logic d_req;
  logic in_acc;
  logic i_done;
  logic d_done;

  assign d_req = dREN | dWEN;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wen_d    = wen_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    fault_d  = fault_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
        // Data normally wins; a held iREN that has watched STARVE_LIMIT data grants goes first.
        if (iREN && (starve_q == STARVE_MAX)) begin
          state_d  = IACC;
          addr_d   = iaddr;
          store_d  = '0;
          wen_d    = 1'b0;
          starve_d = '0;
        end else if (d_req) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
          if (iREN) starve_d = starve_q + 8'd1;
        end else if (iREN) begin
          state_d  = IACC;
          addr_d   = iaddr;
          store_d  = '0;
          wen_d    = 1'b0;
          starve_d = '0;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          state_d = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wen_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wen_q    <= wen_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
      fault_q  <= fault_d;
`endif
    end
  end

  // RAM port is driven only from the values latched at grant.
  always_comb begin
    in_acc   = (state_q == IACC) || (state_q == DACC);
    i_done   = (state_q == IACC) && ramready;
    d_done   = (state_q == DACC) && ramready;
    ramREN   = in_acc && !wen_q;
    ramWEN   = in_acc && wen_q;
    ramaddr  = in_acc ? addr_q  : '0;
    ramstore = in_acc ? store_q : '0;
    iwait    = iREN  && !i_done;
    dwait    = d_req && !d_done;
    iload    = i_done ? ramload : '0;
    dload    = (d_done && !wen_q) ? ramload : '0;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected RAM accesses are queued as requests
// are raised and checked as the arbiter drives them onto the RAM port.
module tb_mem_req_arbiter;
  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, fault;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct packed {
    logic        instr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  mem_req_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .fault(fault)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits for the next RAM access, pops its expectation, answers with ramready on
  // access cycle 'lat'. mode 1 scrambles requester inputs after the grant, mode 2 drops them.
  task automatic serve(input int lat, input logic [31:0] rdata, input int mode, output int waited);
    exp_t        e;
    logic        exp_iw, exp_dw;
    logic [31:0] exp_il, exp_dl;
    waited = 0;
    @(negedge CLK); #1;
    while (!(ramREN || ramWEN)) begin
      if (waited >= 20) begin
        n_cmp++; n_err++;
        $display("FAIL grant_timeout: no RAM enable after %0d cycles, required one", waited);
        return;
      end
      waited++;
      @(negedge CLK); #1;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_access: addr=%h with empty scoreboard", ramaddr);
      return;
    end
    e = sb.pop_front();
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin @(negedge CLK); #1; end
      ramready = (k == lat);
      ramload  = rdata;
      #1;
      n_cmp++;
      if ({ramREN, ramWEN, ramaddr} !== {~e.we, e.we, e.addr}) begin
        n_err++;
        $display("FAIL ram_drive cyc%0d: got REN=%b WEN=%b addr=%h, want REN=%b WEN=%b addr=%h",
                 k, ramREN, ramWEN, ramaddr, ~e.we, e.we, e.addr);
      end
      if (e.we) begin
        n_cmp++;
        if (ramstore !== e.store) begin
          n_err++;
          $display("FAIL ram_store cyc%0d: got %h, want %h", k, ramstore, e.store);
        end
      end
      exp_iw = iREN && !(e.instr && ramready);
      exp_dw = (dREN || dWEN) && !(!e.instr && ramready);
      n_cmp++;
      if ({iwait, dwait} !== {exp_iw, exp_dw}) begin
        n_err++;
        $display("FAIL waits cyc%0d: got iwait=%b dwait=%b, want iwait=%b dwait=%b",
                 k, iwait, dwait, exp_iw, exp_dw);
      end
      exp_il = (e.instr && ramready) ? rdata : 32'h0;
      exp_dl = (!e.instr && !e.we && ramready) ? rdata : 32'h0;
      n_cmp++;
      if ({iload, dload} !== {exp_il, exp_dl}) begin
        n_err++;
        $display("FAIL loads cyc%0d: got iload=%h dload=%h, want iload=%h dload=%h",
                 k, iload, dload, exp_il, exp_dl);
      end
      if (k == 1 && mode == 1) begin
        iaddr  = ~iaddr;
        daddr  = ~daddr;
        dstore = ~dstore;
        dWEN   = ~dWEN;
      end else if (k == 1 && mode == 2) begin
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
      end
    end
    step();
    ramready = 1'b0;
    ramload  = 32'h0;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramready = 1'b1;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h1234_5678;
    #12;
    n_cmp++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
      n_err++;
      $display("FAIL reset_ram: got REN=%b WEN=%b addr=%h store=%h, want all 0",
               ramREN, ramWEN, ramaddr, ramstore);
    end
    n_cmp++;
    if ({iwait, dwait, fault} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_waits: got iwait=%b dwait=%b fault=%b, want 1 1 0", iwait, dwait, fault);
    end
    n_cmp++;
    if ({iload, dload} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_loads: got iload=%h dload=%h, want 0", iload, dload);
    end
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0; ramload = 32'h0;
    @(negedge CLK); RST = 1'b0;
    step();
  endtask

  task automatic test_instr_read();
    int w;
    iREN = 1'b1; iaddr = 32'h100;
    sb.push_back('{instr: 1'b1, we: 1'b0, addr: 32'h100, store: 32'h0});
    serve(2, 32'hDEAD_BEEF, 0, w);
    n_cmp++;
    if (w !== 1) begin
      n_err++;
      $display("FAIL instr_latency: got %0d idle cycles, want 1", w);
    end
    iREN = 1'b0;
    @(negedge CLK); #1;
    n_cmp++;
    if ({ramREN, ramWEN, ramaddr, iload} !== 66'h0) begin
      n_err++;
      $display("FAIL instr_idle: got REN=%b WEN=%b addr=%h iload=%h, want 0",
               ramREN, ramWEN, ramaddr, iload);
    end
    step();
  endtask

  task automatic test_data_priority();
    int w;
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
    sb.push_back('{instr: 1'b0, we: 1'b0, addr: 32'h300, store: 32'h0});
    sb.push_back('{instr: 1'b1, we: 1'b0, addr: 32'h200, store: 32'h0});
    serve(1, 32'hA5A5_0001, 0, w);
    dREN = 1'b0;
    serve(2, 32'h0BAD_F00D, 0, w);
    n_cmp++;
    if (w !== 1) begin
      n_err++;
      $display("FAIL priority_gap: got %0d idle cycles before IACC, want 1", w);
    end
    iREN = 1'b0;
  endtask

  task automatic test_starvation();
    int w;
    iREN = 1'b1; iaddr = 32'h400; dWEN = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < STARVE; i++) begin
        daddr  = 32'h500 + 32'(16 * i);
        dstore = 32'h1000 + 32'(16 * r + i);
        sb.push_back('{instr: 1'b0, we: 1'b1, addr: daddr, store: dstore});
        serve(1, 32'h0, 0, w);
      end
      sb.push_back('{instr: 1'b1, we: 1'b0, addr: 32'h400, store: 32'h0});
      serve(1, 32'hCAFE_0000 + 32'(r), 0, w);
      n_cmp++;
      if (w !== 1) begin
        n_err++;
        $display("FAIL starve_gap round%0d: got %0d idle cycles, want 1", r, w);
      end
    end
    iREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_both_enables();
    int w;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h1234_5678;
    sb.push_back('{instr: 1'b0, we: 1'b1, addr: 32'h40, store: 32'h1234_5678});
    serve(2, 32'hFFFF_0000, 1, w);
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_drop();
    int w;
    dREN = 1'b1; daddr = 32'h700;
    sb.push_back('{instr: 1'b0, we: 1'b0, addr: 32'h700, store: 32'h0});
    serve(3, 32'h7777_0000, 2, w);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({ramREN, ramWEN, dwait, dload} !== 35'h0) begin
        n_err++;
        $display("FAIL drop_idle c%0d: got REN=%b WEN=%b dwait=%b dload=%h, want 0",
                 c, ramREN, ramWEN, dwait, dload);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int w;
    dREN = 1'b1; daddr = 32'h800; ramready = 1'b0;
    step();
    @(negedge CLK); #1;
    n_cmp++;
    if (ramREN !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got ramREN=%b, want 1", ramREN);
    end
    RST = 1'b1; #1;
    n_cmp++;
    if ({ramREN, ramWEN, ramaddr, dwait} !== {34'h0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_async: got REN=%b WEN=%b addr=%h dwait=%b, want 0 0 0 1",
               ramREN, ramWEN, ramaddr, dwait);
    end
    ramready = 1'b1; ramload = 32'h5555_5555;
    @(negedge CLK); #1;
    RST = 1'b0; #1;
    n_cmp++;
    if ({ramREN, ramWEN, dwait, dload} !== {2'b00, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL rstmid_release: got REN=%b WEN=%b dwait=%b dload=%h, want 0 0 1 0",
               ramREN, ramWEN, dwait, dload);
    end
    ramready = 1'b0; ramload = 32'h0;
    sb.push_back('{instr: 1'b0, we: 1'b0, addr: 32'h800, store: 32'h0});
    serve(1, 32'h8888_0000, 0, w);
    dREN = 1'b0;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h900; ramready = 1'b0;
    step();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({ramREN, fault} !== 2'b10) begin
        n_err++;
        $display("FAIL tmo_wait cyc%0d: got ramREN=%b fault=%b, want 1 0", k, ramREN, fault);
      end
    end
    iREN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({fault, ramREN, ramWEN, ramaddr, iwait, dwait} !== {3'b100, 32'h0, 2'b11}) begin
        n_err++;
        $display("FAIL tmo_fault c%0d: got fault=%b REN=%b WEN=%b addr=%h iwait=%b dwait=%b, want 1 0 0 0 1 1",
                 c, fault, ramREN, ramWEN, ramaddr, iwait, dwait);
      end
    end
    iREN = 1'b0; dREN = 1'b0;
    RST = 1'b1; #2;
    n_cmp++;
    if (fault !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear: got fault=%b, want 0", fault);
    end
    @(negedge CLK); RST = 1'b0;
    step();
  endtask
`else
  task automatic test_no_timeout();
    int w;
    dREN = 1'b1; daddr = 32'hA00; ramready = 1'b0;
    sb.push_back('{instr: 1'b0, we: 1'b0, addr: 32'hA00, store: 32'h0});
    step();
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK); #1;
      n_cmp++;
      if ({ramREN, fault, dwait} !== 3'b101) begin
        n_err++;
        $display("FAIL stall cyc%0d: got ramREN=%b fault=%b dwait=%b, want 1 0 1", k, ramREN, fault, dwait);
      end
    end
    serve(1, 32'hABCD_0000, 0, w);
    dREN = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_instr_read();
    test_data_priority();
    test_starvation();
    test_both_enables();
    test_drop();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected accesses never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
